// File: rtl/run_mode_encoder_seq.sv
// rtl/run_mode_encoder_seq.sv - JPEG-LS run-mode encoder: RUNcnt/RUNindex state, hit/interruption/EOL codes
`timescale 1ns/1ps
module run_mode_encoder_seq #(
    parameter int RUNCNT_W = 16,
    parameter int RIDX_W   = 5,
    parameter int RIDX_MAX = 31,
    parameter int CODE_W   = 24,
    parameter int LEN_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_first,
    input  logic              pix_match,
    input  logic              pix_eol,
    output logic [CODE_W-1:0] code_bits,
    output logic [LEN_W-1:0]  code_len,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              run_done,
    output logic [RIDX_W-1:0] ri_index,
    output logic              run_eol
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [RUNCNT_W:0] CNT_ONE  = (RUNCNT_W+1)'(1);
    localparam logic [RIDX_W-1:0] IDX_MAX  = RIDX_W'(RIDX_MAX);
    localparam logic [RIDX_W-1:0] IDX_ONE  = RIDX_W'(1);

    state_t              state_q, state_d;
    logic [RUNCNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [RIDX_W-1:0]   run_idx_q, run_idx_d;
    logic                accept;
    logic                emit;
    logic                ends_run;
    logic [CODE_W-1:0]   code_d;
    logic [LEN_W-1:0]    len_d;
    logic [3:0]          j_cur;
    logic [RUNCNT_W:0]   rg;
    logic [RUNCNT_W:0]   cnt_ext;
    logic [RUNCNT_W:0]   cnt_inc;

    // J table: four entries each for 0..3, pairs for 4..7, then one per index up to 15
    function automatic logic [3:0] j_of(input logic [RIDX_W-1:0] idx);
        int i;
        i = int'(idx);
        if (i < 4)       return 4'd0;
        else if (i < 8)  return 4'd1;
        else if (i < 12) return 4'd2;
        else if (i < 16) return 4'd3;
        else if (i < 24) return 4'(4 + (i - 16) / 2);
        else if (i < 32) return 4'(i - 16);
        else             return 4'd15;
    endfunction

    assign pix_ready = !code_valid || code_ready;
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        run_idx_d = run_idx_q;
        emit      = 1'b0;
        ends_run  = 1'b0;
        code_d    = '0;
        len_d     = '0;
        j_cur     = j_of(run_idx_q);
        rg        = CNT_ONE << j_cur;
        cnt_ext   = (pix_first || state_q == IDLE) ? '0 : {1'b0, run_cnt_q};
        cnt_inc   = cnt_ext + CNT_ONE;

        if (accept) begin
            if (pix_match) begin
                if (cnt_inc == rg) begin
                    emit      = 1'b1;
                    code_d    = CODE_W'(1);
                    len_d     = LEN_W'(1);
                    run_cnt_d = '0;
                    run_idx_d = (run_idx_q == IDX_MAX) ? run_idx_q : run_idx_q + IDX_ONE;
                end else begin
                    run_cnt_d = cnt_inc[RUNCNT_W-1:0];
                end
                // A partial run at end of line is flushed with a single '1'
                if (pix_eol) begin
                    ends_run  = 1'b1;
                    run_cnt_d = '0;
                    if (cnt_inc != rg) begin
                        emit   = 1'b1;
                        code_d = CODE_W'(1);
                        len_d  = LEN_W'(1);
                    end
                end
                state_d = pix_eol ? IDLE : RUN;
            end else begin
                emit      = 1'b1;
                ends_run  = 1'b1;
                code_d    = CODE_W'(cnt_ext & (rg - CNT_ONE));
                len_d     = LEN_W'(j_cur) + LEN_W'(1);
                run_cnt_d = '0;
                run_idx_d = (run_idx_q == '0) ? '0 : run_idx_q - IDX_ONE;
                state_d   = IDLE;
            end
        end

        // Frame start drops any beat offered in the same cycle
        if (frame_start) begin
            state_d   = IDLE;
            run_cnt_d = '0;
            run_idx_d = '0;
            emit      = 1'b0;
            ends_run  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            run_cnt_q  <= '0;
            run_idx_q  <= '0;
            code_valid <= 1'b0;
            code_bits  <= '0;
            code_len   <= '0;
            run_done   <= 1'b0;
            ri_index   <= '0;
            run_eol    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            run_idx_q <= run_idx_d;
            if (emit) begin
                code_valid <= 1'b1;
                code_bits  <= code_d;
                code_len   <= len_d;
            end else if (code_ready) begin
                code_valid <= 1'b0;
            end
            run_done <= ends_run;
            run_eol  <= ends_run && pix_match && pix_eol;
            if (ends_run && !pix_match) begin
                ri_index <= run_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_run_mode_encoder_seq.sv
// tb/tb_run_mode_encoder_seq.sv - scoreboard bench for run_mode_encoder_seq
`timescale 1ns/1ps
module tb_run_mode_encoder_seq;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_first;
    logic        pix_match;
    logic        pix_eol;
    logic [23:0] code_bits;
    logic [4:0]  code_len;
    logic        code_valid;
    logic        code_ready;
    logic        run_done;
    logic [4:0]  ri_index;
    logic        run_eol;

    typedef struct {
        logic [23:0] bits;
        logic [4:0]  len;
    } code_t;

    typedef struct {
        logic       eol;
        logic [4:0] ri;
    } done_t;

    code_t cq[$];
    done_t dq[$];
    int    checks = 0;
    int    fails  = 0;
    int    jtab[32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,
                        4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

    run_mode_encoder_seq dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_first   (pix_first),
        .pix_match   (pix_match),
        .pix_eol     (pix_eol),
        .code_bits   (code_bits),
        .code_len    (code_len),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .run_done    (run_done),
        .ri_index    (ri_index),
        .run_eol     (run_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_code(input logic [23:0] bits, input logic [4:0] len);
        code_t c;
        c.bits = bits;
        c.len  = len;
        cq.push_back(c);
    endtask

    task automatic exp_done(input logic eol, input logic [4:0] ri);
        done_t d;
        d.eol = eol;
        d.ri  = ri;
        dq.push_back(d);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (code_valid && code_ready) begin
                if (cq.size() == 0) begin
                    chk("unexpected_code", {8'h0, code_bits}, 32'hFFFF_FFFF);
                end else begin
                    code_t c;
                    c = cq.pop_front();
                    chk("code_bits", {8'h0, code_bits}, {8'h0, c.bits});
                    chk("code_len", {27'h0, code_len}, {27'h0, c.len});
                end
            end
            if (run_done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_run_done", 32'h1, 32'h0);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("run_eol", {31'h0, run_eol}, {31'h0, d.eol});
                    if (!d.eol) chk("ri_index", {27'h0, ri_index}, {27'h0, d.ri});
                end
            end
        end
    end

    task automatic beat(input logic f, input logic m, input logic e);
        int waited;
        waited = 0;
        pix_valid = 1'b1;
        pix_first = f;
        pix_match = m;
        pix_eol   = e;
        forever begin
            @(negedge clk);
            if (pix_ready) break;
            waited++;
            if (waited > 50) begin
                chk("beat_accept_timeout", 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_first = 1'b0;
        pix_match = 1'b0;
        pix_eol   = 1'b0;
    endtask

    task automatic do_frame_start();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    // Walks RUNindex from 'from' to 'to' with exactly rg matches per index, each ending in a hit
    task automatic ramp(input int from, input int to);
        for (int k = from; k < to; k++) begin
            for (int n = 0; n < (1 << jtab[k]); n++) begin
                if (n == (1 << jtab[k]) - 1) exp_code(24'h1, 5'd1);
                beat(n == 0, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_first   = 1'b0;
        pix_match   = 1'b0;
        pix_eol     = 1'b0;
        code_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code_valid", {31'h0, code_valid}, 32'h0);
        chk("rst_code_bits", {8'h0, code_bits}, 32'h0);
        chk("rst_code_len", {27'h0, code_len}, 32'h0);
        chk("rst_run_done", {31'h0, run_done}, 32'h0);
        chk("rst_ri_index", {27'h0, ri_index}, 32'h0);
        chk("rst_run_eol", {31'h0, run_eol}, 32'h0);
        chk("rst_pix_ready", {31'h0, pix_ready}, 32'h1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Three hits at J=0, then one more to reach RUNindex=4
        exp_code(24'h1, 5'd1); beat(1'b1, 1'b1, 1'b0);
        exp_code(24'h1, 5'd1); beat(1'b0, 1'b1, 1'b0);
        exp_code(24'h1, 5'd1); beat(1'b0, 1'b1, 1'b0);
        exp_code(24'h1, 5'd1); beat(1'b0, 1'b1, 1'b0);
        // RUNindex=4, J=1: match, match (hit -> 5), interrupt at J=1 cnt=0
        beat(1'b1, 1'b1, 1'b0);
        exp_code(24'h1, 5'd1); beat(1'b0, 1'b1, 1'b0);
        exp_code(24'h0, 5'd2); exp_done(1'b0, 5'd5); beat(1'b0, 1'b0, 1'b0);
        // RUNindex now 4: interrupt reports it and decrements to 3
        exp_code(24'h0, 5'd2); exp_done(1'b0, 5'd4); beat(1'b1, 1'b0, 1'b0);
        drain();

        // RUNindex=8, J=2: three matches then interrupt -> 011
        do_frame_start();
        ramp(0, 8);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        exp_code(24'h3, 5'd3); exp_done(1'b0, 5'd8); beat(1'b0, 1'b0, 1'b0);
        // RUNindex=7, J=1: single match at EOL flushes a '1'
        exp_code(24'h1, 5'd1); exp_done(1'b1, 5'd0); beat(1'b1, 1'b1, 1'b1);
        exp_code(24'h0, 5'd2); exp_done(1'b0, 5'd7); beat(1'b1, 1'b0, 1'b0);
        drain();

        // Beat coinciding with frame_start is dropped and RUNindex clears
        frame_start = 1'b1;
        beat(1'b1, 1'b1, 1'b0);
        frame_start = 1'b0;
        // RUNindex=0: match with EOL is a hit only, no extra EOL bit
        exp_code(24'h1, 5'd1); exp_done(1'b1, 5'd0); beat(1'b1, 1'b1, 1'b1);
        exp_code(24'h0, 5'd1); exp_done(1'b0, 5'd1); beat(1'b1, 1'b0, 1'b0);
        drain();

        // RUNindex=31 saturation, then interrupt at cnt=5 with J=15
        do_frame_start();
        ramp(0, 31);
        for (int n = 0; n < 32768; n++) begin
            if (n == 32767) exp_code(24'h1, 5'd1);
            beat(n == 0, 1'b1, 1'b0);
        end
        for (int n = 0; n < 5; n++) beat(n == 0, 1'b1, 1'b0);
        exp_code(24'h000005, 5'd16); exp_done(1'b0, 5'd31); beat(1'b0, 1'b0, 1'b0);
        drain();

        // Back-pressure: RUNindex=30 (J=14) code held while code_ready=0
        code_ready = 1'b0;
        exp_code(24'h0, 5'd15); exp_done(1'b0, 5'd30); beat(1'b1, 1'b0, 1'b0);
        pix_valid = 1'b1;
        pix_first = 1'b1;
        pix_match = 1'b0;
        pix_eol   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_pix_ready", {31'h0, pix_ready}, 32'h0);
            chk("bp_code_valid", {31'h0, code_valid}, 32'h1);
            chk("bp_code_len", {27'h0, code_len}, 32'd15);
        end
        // Held beat is taken on the same edge that retires the held code (J(29)=13)
        exp_code(24'h0, 5'd14); exp_done(1'b0, 5'd29);
        @(posedge clk);
        #1;
        code_ready = 1'b1;
        @(posedge clk);
        #1;
        code_ready = 1'b0;
        pix_valid  = 1'b0;
        @(negedge clk);
        chk("bp_new_code_valid", {31'h0, code_valid}, 32'h1);
        chk("bp_new_code_len", {27'h0, code_len}, 32'd14);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_code_valid", {31'h0, code_valid}, 32'h0);
        chk("async_code_bits", {8'h0, code_bits}, 32'h0);
        chk("async_code_len", {27'h0, code_len}, 32'h0);
        chk("async_run_done", {31'h0, run_done}, 32'h0);
        chk("async_ri_index", {27'h0, ri_index}, 32'h0);
        chk("async_run_eol", {31'h0, run_eol}, 32'h0);
        chk("async_pix_ready", {31'h0, pix_ready}, 32'h1);
        cq.delete();
        dq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        code_ready = 1'b1;
        // After reset RUNindex is 0 again: interrupt gives '0' len 1, ri_index 0
        exp_code(24'h0, 5'd1); exp_done(1'b0, 5'd0); beat(1'b1, 1'b0, 1'b0);
        drain();

        chk("code_queue_empty", cq.size(), 32'h0);
        chk("done_queue_empty", dq.size(), 32'h0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
